// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer for the 5-stage core: PC / IF-ID / ID-EX enables, bubble and flush.
// Control outputs are combinational from state and inputs; state and counters update each clk.
// A data-memory wait freezes every stage; a wait longer than TIMEOUT cycles sets err_timeout.
module pipe_seq_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      ins_id,
  input  logic             id_valid,
  input  logic             br_taken,
  input  logic             dm_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             bubble,
  output logic             flush,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    LDUSE   = 3'd2,
    FLUSH   = 3'd3,
    MEMWAIT = 3'd4
  } state_t;

  localparam int               WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t            state_q, state_d;
  logic              ld_pend_q;
  logic [4:0]        ld_rd_q;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              err_q, err_d;

  // Raw (pre-reset-gating) control outputs.
  logic pc_en_d, ifid_en_d, idex_en_d, bubble_d, flush_d;

  // Instruction decode; a bubble in ID never decodes as anything.
  logic [5:0] opcode;
  logic       is_ld, is_jmp, hz_ld;
  logic       unused_ins_bits;

  assign opcode = ins_id[31:26];
  assign is_ld  = id_valid && (opcode == 6'b010100);
  assign is_jmp = id_valid && (opcode == 6'b011000);
  // Register 0 is hard-wired zero, so a load into r0 never creates a hazard.
  assign hz_ld  = ld_pend_q && (ld_rd_q != 5'd0) && id_valid &&
                  ((ins_id[20:16] == ld_rd_q) || (ins_id[15:11] == ld_rd_q));
  assign unused_ins_bits = ^ins_id[10:0];

  // Next state, wait counter and Mealy control outputs, in priority dm_busy > br_taken > hz_ld > JMP.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    pc_en_d    = 1'b0;
    ifid_en_d  = 1'b0;
    idex_en_d  = 1'b0;
    bubble_d   = 1'b0;
    flush_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (dm_busy) begin
          state_d    = MEMWAIT;
          wait_cnt_d = WAIT_ONE;
        end else if (br_taken) begin
          pc_en_d   = 1'b1;
          ifid_en_d = 1'b1;
          idex_en_d = 1'b1;
          flush_d   = 1'b1;
          bubble_d  = 1'b1;
          state_d   = FLUSH;
        end else if (hz_ld) begin
          idex_en_d = 1'b1;
          bubble_d  = 1'b1;
          state_d   = LDUSE;
        end else begin
          pc_en_d   = 1'b1;
          ifid_en_d = 1'b1;
          idex_en_d = 1'b1;
          flush_d   = is_jmp;
        end
      end
      LDUSE, FLUSH: begin
        // EX holds a bubble here, so br_taken is not looked at.
        if (dm_busy) begin
          state_d    = MEMWAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          pc_en_d   = 1'b1;
          ifid_en_d = 1'b1;
          idex_en_d = 1'b1;
          flush_d   = (state_q == FLUSH);
          state_d   = RUN;
        end
      end
      MEMWAIT: begin
        if (!dm_busy) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          err_d      = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // While reset is asserted nothing may pulse, whatever state is current.
  assign pc_en   = pc_en_d   && !reset;
  assign ifid_en = ifid_en_d && !reset;
  assign idex_en = idex_en_d && !reset;
  assign bubble  = bubble_d  && !reset;
  assign flush   = flush_d   && !reset;

  // State, load tracking, wait/stall counters and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ld_pend_q   <= 1'b0;
      ld_rd_q     <= 5'd0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      // Track the destination of whatever instruction moves into EX; a bubble is never a load.
      if (idex_en) begin
        ld_pend_q <= is_ld && !bubble;
        ld_rd_q   <= ins_id[25:21];
      end
      if ((state_q != IDLE) && !pc_en && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign state       = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl: load-use, r0 loads, jumps, taken branches, memory waits, timeout, reset.
// Inputs change on the falling edge; Mealy outputs are checked 1 ns later, registered ones after the rising edge.
// Expected values are hand-computed constants for the default TIMEOUT=64, CNT_W=16.
module tb_pipe_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] ins_id;
  logic        id_valid;
  logic        br_taken;
  logic        dm_busy;
  logic        pc_en, ifid_en, idex_en, bubble, flush;
  logic [2:0]  state;
  logic [15:0] stall_cnt;
  logic        err_timeout;
  logic [4:0]  en_v;

  int vectors;
  int miscompares;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] LD_R5   = {6'b010100, 5'd5, 5'd0, 5'd0, 11'd0};
  localparam logic [31:0] ADD_R5  = {6'b000000, 5'd6, 5'd5, 5'd7, 11'd0};
  localparam logic [31:0] LD_R0   = {6'b010100, 5'd0, 5'd0, 5'd0, 11'd0};
  localparam logic [31:0] ADD_R0  = {6'b000000, 5'd6, 5'd0, 5'd0, 11'd0};
  localparam logic [31:0] JMP     = {6'b011000, 26'd0};

  // {pc_en, ifid_en, idex_en, bubble, flush}
  localparam logic [4:0] EN_NONE  = 5'b00000;
  localparam logic [4:0] EN_ALL   = 5'b11100;
  localparam logic [4:0] EN_LDUSE = 5'b00110;
  localparam logic [4:0] EN_JMP   = 5'b11101;
  localparam logic [4:0] EN_BR    = 5'b11111;

  pipe_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ins_id      (ins_id),
    .id_valid    (id_valid),
    .br_taken    (br_taken),
    .dm_busy     (dm_busy),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .bubble      (bubble),
    .flush       (flush),
    .state       (state),
    .stall_cnt   (stall_cnt),
    .err_timeout (err_timeout)
  );

  assign en_v = {pc_en, ifid_en, idex_en, bubble, flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and let combinational outputs settle.
  task automatic cyc(input logic rst, input logic st, input logic [31:0] ins,
                     input logic vld, input logic br, input logic busy);
    @(negedge clk);
    reset    = rst;
    start    = st;
    ins_id   = ins;
    id_valid = vld;
    br_taken = br;
    dm_busy  = busy;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    start    = 1'b0;
    ins_id   = NOP;
    id_valid = 1'b0;
    br_taken = 1'b0;
    dm_busy  = 1'b0;

    // Reset state.
    cyc(1'b1, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_err",   32'(err_timeout), 32'd0);
    check("rst_en",    32'(en_v), 32'(EN_NONE));

    // IDLE ignores everything but start.
    cyc(1'b0, 1'b1, NOP, 1'b1, 1'b0, 1'b0);
    check("idle_en", 32'(en_v), 32'(EN_NONE));

    // Load-use on r5: one stall cycle with bubble, then LDUSE releases.
    cyc(1'b0, 1'b0, LD_R5, 1'b1, 1'b0, 1'b0);
    check("run_state", 32'(state), 32'd1);
    check("ld_en",     32'(en_v), 32'(EN_ALL));
    cyc(1'b0, 1'b0, ADD_R5, 1'b1, 1'b0, 1'b0);
    check("hz_en", 32'(en_v), 32'(EN_LDUSE));
    cyc(1'b0, 1'b0, ADD_R5, 1'b1, 1'b0, 1'b0);
    check("lduse_state", 32'(state), 32'd2);
    check("lduse_en",    32'(en_v), 32'(EN_ALL));
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b0);
    check("lduse_back_state", 32'(state), 32'd1);
    check("lduse_stall",      32'(stall_cnt), 32'd1);
    check("after_lduse_en",   32'(en_v), 32'(EN_ALL));

    // Load into r0 never stalls.
    cyc(1'b0, 1'b0, LD_R0, 1'b1, 1'b0, 1'b0);
    check("ld_r0_en", 32'(en_v), 32'(EN_ALL));
    cyc(1'b0, 1'b0, ADD_R0, 1'b1, 1'b0, 1'b0);
    check("use_r0_en", 32'(en_v), 32'(EN_ALL));

    // A consumer marked invalid in ID is not a hazard.
    cyc(1'b0, 1'b0, LD_R5, 1'b1, 1'b0, 1'b0);
    check("ld_r5b_en", 32'(en_v), 32'(EN_ALL));
    cyc(1'b0, 1'b0, ADD_R5, 1'b0, 1'b0, 1'b0);
    check("invalid_use_en", 32'(en_v), 32'(EN_ALL));

    // JMP flushes for one cycle and stays in RUN.
    cyc(1'b0, 1'b0, JMP, 1'b1, 1'b0, 1'b0);
    check("jmp_en", 32'(en_v), 32'(EN_JMP));
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b0);
    check("jmp_state",   32'(state), 32'd1);
    check("after_jmp_en", 32'(en_v), 32'(EN_ALL));

    // Taken branch: flush in RUN and FLUSH; br_taken held high is ignored in FLUSH.
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b1, 1'b0);
    check("br_en", 32'(en_v), 32'(EN_BR));
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b1, 1'b0);
    check("flush_state", 32'(state), 32'd3);
    check("flush_en",    32'(en_v), 32'(EN_JMP));
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b0);
    check("flush_back_state", 32'(state), 32'd1);
    check("flush_stall",      32'(stall_cnt), 32'd1);

    // Memory wait: busy seen in RUN and one MEMWAIT cycle, then the release cycle
    // in MEMWAIT is still frozen -> three frozen cycles, RUN on the fourth.
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b1);
    check("busy_run_en", 32'(en_v), 32'(EN_NONE));
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b1);
    check("memwait_state", 32'(state), 32'd4);
    check("memwait_en",    32'(en_v), 32'(EN_NONE));
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b0);
    check("memwait_rel_en", 32'(en_v), 32'(EN_NONE));
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b0);
    check("memwait_back_state", 32'(state), 32'd1);
    check("memwait_stall",      32'(stall_cnt), 32'd4);
    check("memwait_err",        32'(err_timeout), 32'd0);
    check("memwait_back_en",    32'(en_v), 32'(EN_ALL));

    // Timeout: busy held; 1 RUN cycle + 64 MEMWAIT cycles frozen, then err and RUN.
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b1);
    repeat (63) cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b1);
    check("to_last_state", 32'(state), 32'd4);
    check("to_last_err",   32'(err_timeout), 32'd0);
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b0);
    check("to_state", 32'(state), 32'd1);
    check("to_err",   32'(err_timeout), 32'd1);
    check("to_stall", 32'(stall_cnt), 32'd69);
    check("to_en",    32'(en_v), 32'(EN_ALL));

    // dm_busy beats br_taken; then reset while in MEMWAIT.
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b1, 1'b1);
    check("busy_br_en", 32'(en_v), 32'(EN_NONE));
    cyc(1'b1, 1'b0, NOP, 1'b1, 1'b0, 1'b1);
    check("rst_mw_state", 32'(state), 32'd4);
    check("rst_mw_en",    32'(en_v), 32'(EN_NONE));
    cyc(1'b0, 1'b0, NOP, 1'b1, 1'b0, 1'b0);
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_stall", 32'(stall_cnt), 32'd0);
    check("post_rst_err",   32'(err_timeout), 32'd0);
    check("post_rst_en",    32'(en_v), 32'(EN_NONE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
